ram_arbiter: RTL

//   Shares the single-port synchronous RAM between two requesters: instruction fetch (F, read-only)
//   and data load/store (D). Round-robin arbitration with a per-cycle request/ready handshake.

---
 rtl/ram_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM
// between instruction fetch (read-only) and data load/store.
`ifndef ARCH_WIDTH
`define ARCH_WIDTH 32
`endif

module ram_arbiter #(
  parameter int ARCH_WIDTH = `ARCH_WIDTH,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  hold,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_ready,
  output logic                  f_rvalid,
  output logic [ARCH_WIDTH-1:0] f_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [ARCH_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [ARCH_WIDTH-1:0] d_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [ARCH_WIDTH-1:0] ram_wdata,
  input  logic [ARCH_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t rd_owner, rd_next;
  logic   last_grant;
  logic   open;

  // clear gates the grant so nothing reaches the RAM during reset
  assign open    = clear & ~hold;
  assign f_ready = open & f_req & (~d_req | last_grant);
  assign d_ready = open & d_req & (~f_req | ~last_grant);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      f_ready: begin
        ram_en   = 1'b1;
        ram_addr = f_addr;
      end
      d_ready: begin
        ram_en    = 1'b1;
        ram_we    = d_we;
        ram_addr  = d_addr;
        ram_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_next = OWN_NONE;
    unique case (1'b1)
      f_ready:         rd_next = OWN_F;
      d_ready & ~d_we: rd_next = OWN_D;
      default:         rd_next = OWN_NONE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rd_owner   <= OWN_NONE;
      last_grant <= 1'b1;
    end else begin
      rd_owner <= rd_next;
      if (f_ready)      last_grant <= 1'b0;
      else if (d_ready) last_grant <= 1'b1;
    end
  end

  assign f_rvalid = (rd_owner == OWN_F);
  assign d_rvalid = (rd_owner == OWN_D);
  assign f_rdata  = f_rvalid ? ram_rdata : '0;
  assign d_rdata  = d_rvalid ? ram_rdata : '0;

endmodule
